icache_assoc: RTL and testbench

- Parametrised successor to the fixed direct-mapped instruction cache inside the per-CPU caches block.
- Set-associative (1 or 2 ways), configurable set count and words per block, with pseudo-LRU replacement.
- Adds a full-cache invalidate and hit/miss performance counters.
- Sits between the datapath fetch port and the memory-controller instruction port.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_way.sv | 55 +++++
 rtl/icache_assoc.sv | 181 ++++++++++++++++++
 tb/tb_icache_assoc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic {IDLE, FILL} icache_state_t;

  typedef logic [31:0] word_t;

  function automatic int offsetWidth(input int words);
    return $clog2(words);
  endfunction

  function automatic int indexWidth(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagWidth(input int sets, input int words);
    return 32 - 2 - $clog2(sets) - $clog2(words);
  endfunction

  // Zero-width fields still need a 1-bit carrier signal.
  function automatic int atLeastOne(input int w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and block data, one read port and one fill write port.
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int WORDS = 2,
  localparam int IDXW = indexWidth(SETS),
  localparam int OFFB = atLeastOne(offsetWidth(WORDS)),
  localparam int TAGW = tagWidth(SETS, WORDS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IDXW-1:0] rdIdx_i,
  input  logic [OFFB-1:0] rdOff_i,
  output logic            rdValid_o,
  output logic [TAGW-1:0] rdTag_o,
  output word_t           rdData_o,
  input  logic [IDXW-1:0] wrIdx_i,
  input  logic [OFFB-1:0] wrOff_i,
  input  logic            wrWordEn_i,
  input  word_t           wrData_i,
  input  logic            wrTagEn_i,
  input  logic [TAGW-1:0] wrTag_i,
  input  logic            clear_i
);

  logic [SETS-1:0] valid_q;
  logic [TAGW-1:0] tag_q  [SETS];
  word_t           data_q [SETS][WORDS];

  // Only the valid bits need reset; tag and data are meaningless until valid is set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (wrTagEn_i) begin
      valid_q[wrIdx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wrWordEn_i) begin
      data_q[wrIdx_i][wrOff_i] <= wrData_i;
    end
    if (wrTagEn_i) begin
      tag_q[wrIdx_i] <= wrTag_i;
    end
  end

  assign rdValid_o = valid_q[rdIdx_i];
  assign rdTag_o   = tag_q[rdIdx_i];
  assign rdData_o  = data_q[rdIdx_i][rdOff_i];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways) with pseudo-LRU replacement,
// whole-cache invalidate and hit/miss counters, between fetch port and memory.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int CPUID = 0,
  parameter int SETS  = 8,
  parameter int WAYS  = 2,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output word_t       imemload,
  input  logic        inval,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  word_t       iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDXW = indexWidth(SETS);
  localparam int OFFW = offsetWidth(WORDS);
  localparam int OFFB = atLeastOne(OFFW);
  localparam int TAGW = tagWidth(SETS, WORDS);
  localparam int BLKW = TAGW + IDXW;

  if (WAYS < 1 || WAYS > 2 || CPUID < 0) begin : gBadConfig
    $error("icache_assoc: WAYS must be 1 or 2 and CPUID non-negative");
  end

  icache_state_t   state_q;
  logic [OFFB-1:0] cnt_q;
  logic [BLKW-1:0] missBlk_q;
  logic            victim_q;
  logic            pendInval_q;
  logic [31:0]     hitCount_q;
  logic [31:0]     missCount_q;

  logic [IDXW-1:0] reqIdx;
  logic [OFFB-1:0] reqOff;
  logic [TAGW-1:0] reqTag;
  logic [IDXW-1:0] fillIdx;
  logic [TAGW-1:0] fillTag;
  logic [1:0]      unusedByteOff;

  assign reqIdx        = imemaddr[2+OFFW +: IDXW];
  assign reqOff        = (OFFW > 0) ? imemaddr[2 +: OFFB] : '0;
  assign reqTag        = imemaddr[31 -: TAGW];
  assign fillIdx       = missBlk_q[IDXW-1:0];
  assign fillTag       = missBlk_q[BLKW-1 -: TAGW];
  assign unusedByteOff = imemaddr[1:0];

  logic [WAYS-1:0] wayValid;
  logic [TAGW-1:0] wayTag  [WAYS];
  word_t           wayData [WAYS];

  logic  invalNow, lookup, fillAccept, fillLast, clearAll, missStart;
  logic  hitAny, hitWay, lruVictim, victimSel;
  word_t hitData;

  always_comb begin
    hitAny  = 1'b0;
    hitWay  = 1'b0;
    hitData = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (wayValid[w] && wayTag[w] == reqTag) begin
        hitAny  = 1'b1;
        hitWay  = 1'(w);
        hitData = wayData[w];
      end
    end
  end

  // A pending invalidate owns its IDLE cycle: no hit, no miss, no LRU update.
  assign invalNow   = inval | pendInval_q;
  assign lookup     = (state_q == IDLE) && imemREN && !invalNow;
  assign ihit       = lookup && hitAny;
  assign imemload   = ihit ? hitData : '0;
  assign missStart  = lookup && !hitAny;
  assign clearAll   = (state_q == IDLE) && invalNow;
  assign fillAccept = (state_q == FILL) && !iwait;
  assign fillLast   = fillAccept && (cnt_q == OFFB'(WORDS - 1));

  assign iREN       = (state_q == FILL);
  assign iaddr      = iREN ? ((32'(missBlk_q) << (OFFW + 2)) | (32'(cnt_q) << 2)) : '0;
  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;

  for (genvar w = 0; w < WAYS; w++) begin : gWay
    icache_way #(
      .SETS  (SETS),
      .WORDS (WORDS)
    ) uWay (
      .clk_i      (CLK),
      .rst_i      (RST),
      .rdIdx_i    (reqIdx),
      .rdOff_i    (reqOff),
      .rdValid_o  (wayValid[w]),
      .rdTag_o    (wayTag[w]),
      .rdData_o   (wayData[w]),
      .wrIdx_i    (fillIdx),
      .wrOff_i    (cnt_q),
      .wrWordEn_i (fillAccept && victim_q == 1'(w)),
      .wrData_i   (iload),
      .wrTagEn_i  (fillLast && victim_q == 1'(w)),
      .wrTag_i    (fillTag),
      .clear_i    (clearAll)
    );
  end

  // Each LRU bit names the way to evict next in its set.
  if (WAYS == 2) begin : gLru
    logic [SETS-1:0] lru_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        lru_q <= '0;
      end else if (ihit) begin
        lru_q[reqIdx] <= ~hitWay;
      end else if (fillLast) begin
        lru_q[fillIdx] <= ~victim_q;
      end
    end

    assign lruVictim = lru_q[reqIdx];
  end else begin : gNoLru
    assign lruVictim = 1'b0;
  end

  assign victimSel = (WAYS == 1)             ? 1'b0 :
                     !wayValid[0]            ? 1'b0 :
                     !wayValid[WAYS-1]       ? 1'b1 : lruVictim;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      missBlk_q   <= '0;
      victim_q    <= 1'b0;
      pendInval_q <= 1'b0;
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else begin
      if (ihit) begin
        hitCount_q <= hitCount_q + 32'd1;
      end
      if (missStart) begin
        missCount_q <= missCount_q + 32'd1;
      end
      case (state_q)
        IDLE: begin
          pendInval_q <= 1'b0;
          if (missStart) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            missBlk_q <= imemaddr[31 -: BLKW];
            victim_q  <= victimSel;
          end
        end
        FILL: begin
          if (inval) begin
            pendInval_q <= 1'b1;
          end
          if (fillLast) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (fillAccept) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: a 2-way instance checked every cycle against a
// recency-ordered cache model, plus a 1-way instance checked by hand-computed values.
module tb_icache_assoc;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        ren2 = 1'b0, inval2 = 1'b0, iwait2 = 1'b1;
  logic [31:0] addr2 = '0, iload2 = '0;
  logic        ihit2, iren2;
  logic [31:0] imemload2, iaddr2, hits2, misses2;

  logic        ren1 = 1'b0, inval1 = 1'b0, iwait1 = 1'b1;
  logic [31:0] addr1 = '0, iload1 = '0;
  logic        ihit1, iren1;
  logic [31:0] imemload1, iaddr1, hits1, misses1;

  int checkCnt = 0;
  int passCnt  = 0;
  int left2    = 2;
  int left1    = 2;

  always #5 CLK = ~CLK;

  icache_assoc #(.CPUID(0), .SETS(8), .WAYS(2), .WORDS(2)) uDut2 (
    .CLK(CLK), .RST(RST), .imemREN(ren2), .imemaddr(addr2), .ihit(ihit2),
    .imemload(imemload2), .inval(inval2), .iREN(iren2), .iaddr(iaddr2),
    .iwait(iwait2), .iload(iload2), .hit_count(hits2), .miss_count(misses2)
  );

  icache_assoc #(.CPUID(1), .SETS(8), .WAYS(1), .WORDS(2)) uDut1 (
    .CLK(CLK), .RST(RST), .imemREN(ren1), .imemaddr(addr1), .ihit(ihit1),
    .imemload(imemload1), .inval(inval1), .iREN(iren1), .iaddr(iaddr1),
    .iwait(iwait1), .iload(iload1), .hit_count(hits1), .miss_count(misses1)
  );

  // Backing memory: two fixed words from the test plan, a recognisable pattern elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h40) return 32'h1111_0000;
    if (a == 32'h44) return 32'h2222_0000;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Memory responders: two not-ready cycles, then the word is presented with iwait=0.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (iren2) begin
        if (left2 > 0) begin iwait2 = 1'b1; left2--; end
        else begin iwait2 = 1'b0; iload2 = memWord(iaddr2); left2 = 2; end
      end else begin
        iwait2 = 1'b1; left2 = 2;
      end
      if (iren1) begin
        if (left1 > 0) begin iwait1 = 1'b1; left1--; end
        else begin iwait1 = 1'b0; iload1 = memWord(iaddr1); left1 = 2; end
      end else begin
        iwait1 = 1'b1; left1 = 2;
      end
    end
  end

  // Model: per set, a queue of resident block numbers ordered most-recent first.
  int unsigned mdlSet [8][$];
  bit          mdlBusy = 1'b0, mdlPend = 1'b0;
  logic [31:0] mdlBase = '0, mdlHits = '0, mdlMisses = '0;
  int          mdlCnt = 0;

  function automatic int mdlFind(input int unsigned blk);
    foreach (mdlSet[blk % 8][i]) if (mdlSet[blk % 8][i] == blk) return i;
    return -1;
  endfunction

  task automatic mdlClear();
    for (int s = 0; s < 8; s++) mdlSet[s].delete();
  endtask

  task automatic mdlTouch(input int unsigned blk);
    int pos = mdlFind(blk);
    mdlSet[blk % 8].delete(pos);
    mdlSet[blk % 8].push_front(blk);
  endtask

  task automatic mdlInsert(input int unsigned blk);
    if (mdlSet[blk % 8].size() == 2) void'(mdlSet[blk % 8].pop_back());
    mdlSet[blk % 8].push_front(blk);
  endtask

  // Compare process: mid-cycle check of the 2-way DUT, then advance the model to the next edge.
  initial begin
    bit          expHit;
    logic [31:0] expLoad;
    forever begin
      @(negedge CLK);
      if (RST) begin
        mdlClear();
        mdlBusy = 1'b0; mdlPend = 1'b0; mdlHits = '0; mdlMisses = '0; mdlCnt = 0;
        checkOutput("rst_iREN", 32'(iren2), 32'd0);
        checkOutput("rst_ihit", 32'(ihit2), 32'd0);
        checkOutput("rst_hit_count", hits2, 32'd0);
        checkOutput("rst_miss_count", misses2, 32'd0);
      end else begin
        expHit  = !mdlBusy && ren2 && !inval2 && !mdlPend && (mdlFind(addr2 >> 3) >= 0);
        expLoad = expHit ? memWord(addr2) : 32'd0;
        checkOutput("ihit", 32'(ihit2), 32'(expHit));
        checkOutput("imemload", imemload2, expLoad);
        checkOutput("iREN", 32'(iren2), 32'(mdlBusy));
        if (mdlBusy) checkOutput("iaddr", iaddr2, mdlBase + 32'(4 * mdlCnt));
        checkOutput("hit_count", hits2, mdlHits);
        checkOutput("miss_count", misses2, mdlMisses);
        if (mdlBusy) begin
          if (inval2) mdlPend = 1'b1;
          if (!iwait2) begin
            mdlCnt++;
            if (mdlCnt == 2) begin mdlInsert(mdlBase >> 3); mdlBusy = 1'b0; end
          end
        end else if (inval2 || mdlPend) begin
          mdlClear();
          mdlPend = 1'b0;
        end else if (ren2) begin
          if (expHit) begin
            mdlTouch(addr2 >> 3);
            mdlHits++;
          end else begin
            mdlMisses++;
            mdlBusy = 1'b1;
            mdlBase = addr2 & ~32'h7;
            mdlCnt  = 0;
          end
        end
      end
    end
  end

  task automatic stepCycle();
    @(posedge CLK); #1;
  endtask

  // Hold a fetch until it hits; returns cycles waited and the word, consuming the hit cycle.
  task automatic applyStimulus(input bit sel, input logic [31:0] a, output int lat, output logic [31:0] data);
    bit got = 1'b0;
    if (sel) begin ren1 = 1'b1; addr1 = a; end
    else begin ren2 = 1'b1; addr2 = a; end
    lat  = 0;
    data = '0;
    while (!got && lat <= 40) begin
      @(negedge CLK);
      if (sel ? ihit1 : ihit2) begin
        got  = 1'b1;
        data = sel ? imemload1 : imemload2;
      end else begin
        lat++;
      end
      stepCycle();
    end
    if (!got) begin
      checkCnt++;
      $display("[TB] FAIL fetch_timeout: address 0x%08h got no hit within 40 cycles, required a hit", a);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] d;

    repeat (2) stepCycle();
    checkOutput("reset_iaddr", iaddr2, 32'd0);
    checkOutput("reset_imemload", imemload2, 32'd0);
    RST = 1'b0;
    stepCycle();

    $display("[TB] cold miss then same-block hit");
    applyStimulus(0, 32'h40, lat, d);
    checkOutput("t1_miss_latency", 32'(lat), 32'd7);
    checkOutput("t1_miss_data", d, 32'h1111_0000);
    checkOutput("t1_miss_count", misses2, 32'd1);
    applyStimulus(0, 32'h44, lat, d);
    checkOutput("t1_hit_latency", 32'(lat), 32'd0);
    checkOutput("t1_hit_data", d, 32'h2222_0000);
    checkOutput("t1_hit_count", hits2, 32'd2);

    $display("[TB] replacement in set 0");
    applyStimulus(0, 32'h80, lat, d);
    checkOutput("t2_fill80_latency", 32'(lat), 32'd7);
    checkOutput("t2_fill80_data", d, 32'hFF7F_0080);
    applyStimulus(0, 32'h40, lat, d);
    checkOutput("t2_hit40_latency", 32'(lat), 32'd0);
    applyStimulus(0, 32'hC0, lat, d);
    checkOutput("t2_missC0_latency", 32'(lat), 32'd7);
    applyStimulus(0, 32'h40, lat, d);
    checkOutput("t2_rehit40_latency", 32'(lat), 32'd0);
    applyStimulus(0, 32'h80, lat, d);
    checkOutput("t2_remiss80_latency", 32'(lat), 32'd7);
    checkOutput("t2_miss_count", misses2, 32'd4);

    $display("[TB] address change during fill");
    ren2 = 1'b0; inval2 = 1'b1;
    stepCycle();
    inval2 = 1'b0; ren2 = 1'b1; addr2 = 32'h40;
    repeat (4) stepCycle();
    checkOutput("t3_iaddr_second_word", iaddr2, 32'h44);
    applyStimulus(0, 32'h100, lat, d);
    checkOutput("t3_new_latency", 32'(lat), 32'd10);
    checkOutput("t3_new_data", d, 32'hFEFF_0100);
    applyStimulus(0, 32'h40, lat, d);
    checkOutput("t3_completed_line_latency", 32'(lat), 32'd0);
    checkOutput("t3_completed_line_data", d, 32'h1111_0000);

    $display("[TB] invalidate during fill");
    ren2 = 1'b0; inval2 = 1'b1;
    stepCycle();
    inval2 = 1'b0; ren2 = 1'b1; addr2 = 32'h40;
    repeat (2) stepCycle();
    inval2 = 1'b1;
    stepCycle();
    inval2 = 1'b0;
    applyStimulus(0, 32'h40, lat, d);
    checkOutput("t4_refetch_latency", 32'(lat), 32'd12);
    checkOutput("t4_miss_count", misses2, 32'd8);

    $display("[TB] asynchronous reset during fill");
    ren2 = 1'b1; addr2 = 32'h80;
    repeat (3) stepCycle();
    checkOutput("t5_iREN_before_reset", 32'(iren2), 32'd1);
    #2;
    RST = 1'b1; ren2 = 1'b0;
    #1;
    checkOutput("t5_async_iREN", 32'(iren2), 32'd0);
    checkOutput("t5_async_hit_count", hits2, 32'd0);
    checkOutput("t5_async_miss_count", misses2, 32'd0);
    checkOutput("t5_async_miss_count_1way", misses1, 32'd0);
    stepCycle();
    RST = 1'b0;
    applyStimulus(0, 32'h40, lat, d);
    checkOutput("t5_post_reset_latency", 32'(lat), 32'd7);
    checkOutput("t5_post_reset_miss_count", misses2, 32'd1);
    ren2 = 1'b0;

    $display("[TB] direct-mapped configuration");
    applyStimulus(1, 32'h40, lat, d);
    checkOutput("t6_first40_latency", 32'(lat), 32'd7);
    checkOutput("t6_first40_data", d, 32'h1111_0000);
    applyStimulus(1, 32'h80, lat, d);
    checkOutput("t6_80_latency", 32'(lat), 32'd7);
    checkOutput("t6_80_data", d, 32'hFF7F_0080);
    applyStimulus(1, 32'h40, lat, d);
    checkOutput("t6_second40_latency", 32'(lat), 32'd7);
    checkOutput("t6_miss_count", misses1, 32'd3);
    checkOutput("t6_hit_count", hits1, 32'd3);
    ren1 = 1'b0;
    stepCycle();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
